csr_access_ctrl: RTL and testbench

- Sequences one CSR instruction at a time against the CSR storage block.
- Accepts a decoded CSRRW/CSRRS/CSRRC request (register or immediate form) over a valid/ready handshake.
- Checks legality, reads the old value, computes and commits the new value, then returns the old value (or an illegal-instruction flag) to the pipeline over a second valid/ready handshake.
- Sits between decode/execute and the CSR storage/counter block.

---
 rtl/csr_pkg.sv | 41 ++++
 rtl/csr_legal_check.sv | 39 +++
 rtl/csr_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_csr_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types for the CSR access controller.
// Holds privilege, op, state encodings and address-field positions.
package csr_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } priv_mode_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_t;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_ctrl_state_t;

  // addr[11:10] = read-only field, addr[9:8] = lowest privilege
  localparam int         RO_HI   = 11;
  localparam int         PRIV_LO = 8;
  localparam logic [1:0] RO_ENC  = 2'b11;

  function automatic csr_op_t f3_op(input logic [2:0] f3);
    return csr_op_t'(f3[1:0]);
  endfunction

endpackage

// File: rtl/csr_legal_check.sv
// Combinational legality check for a latched CSR instruction.
// addr_hi_i carries addr[11:8]: RO field then privilege field.
module csr_legal_check
  import csr_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [3:0] addr_hi_i,
  input  logic [4:0] rs1_field_i,
  input  logic [1:0] priv_mode_i,
  input  logic       csr_exists_i,
  output logic       illegal_o,
  output logic       do_read_o,
  output logic       do_write_o
);

  csr_op_t op;
  logic    unused_f3;

  assign op        = f3_op(funct3_i);
  assign unused_f3 = funct3_i[2];

  always_comb begin
    do_read_o  = 1'b1;
    do_write_o = 1'b1;
    unique case (op)
      OP_RW:   do_read_o  = 1'b1;
      default: do_write_o = (rs1_field_i != 5'd0);
    endcase
    if (op == OP_RW) begin
      do_write_o = 1'b1;
    end
    illegal_o = (op == OP_NONE)
              | !csr_exists_i
              | (priv_mode_i < addr_hi_i[1:0])
              | (do_write_o && addr_hi_i[3:2] == RO_ENC);
  end

  // rd==x0 only suppresses the read for RW; folded in by the top.
endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences one CSR read-modify-write per request between
// the pipeline and the CSR storage block.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [4:0]            req_rs1_field,
  input  logic [XLEN-1:0]       req_rs1_val,
  input  logic                  req_rd_is_x0,
  input  logic [1:0]            priv_mode,
  input  logic                  flush,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  input  logic                  csr_exists,
  output logic                  csr_rd_en,
  input  logic [XLEN-1:0]       csr_rd_data,
  output logic                  csr_wr_en,
  output logic [XLEN-1:0]       csr_wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rd_value,
  output logic                  resp_illegal,
  output logic                  busy
);

  csr_ctrl_state_t       state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]            rs1f_q, rs1f_d;
  logic [XLEN-1:0]       src_q, src_d;
  logic                  rdx0_q, rdx0_d;
  logic [XLEN-1:0]       rv_q, rv_d;
  logic                  ill_q, ill_d;

  logic            illegal, do_read, do_write, chk_rd;
  logic [XLEN-1:0] old_val, new_val;

  csr_legal_check u_legal (
    .funct3_i    (f3_q),
    .addr_hi_i   (addr_q[RO_HI:PRIV_LO]),
    .rs1_field_i (rs1f_q),
    .priv_mode_i (priv_mode),
    .csr_exists_i(csr_exists),
    .illegal_o   (illegal),
    .do_read_o   (chk_rd),
    .do_write_o  (do_write)
  );

  assign do_read = chk_rd && !(f3_op(f3_q) == OP_RW && rdx0_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      rs1f_q  <= '0;
      src_q   <= '0;
      rdx0_q  <= 1'b0;
      rv_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      rs1f_q  <= rs1f_d;
      src_q   <= src_d;
      rdx0_q  <= rdx0_d;
      rv_q    <= rv_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    rs1f_d      = rs1f_q;
    src_d       = src_q;
    rdx0_d      = rdx0_q;
    rv_d        = rv_q;
    ill_d       = ill_q;
    req_ready   = 1'b0;
    csr_rd_en   = 1'b0;
    csr_wr_en   = 1'b0;
    csr_wr_data = '0;
    resp_valid  = 1'b0;
    old_val     = '0;
    new_val     = '0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          f3_d   = req_funct3;
          addr_d = req_addr;
          rs1f_d = req_rs1_field;
          src_d  = req_funct3[2]
                 ? {{(XLEN-5){1'b0}}, req_rs1_field}
                 : req_rs1_val;
          rdx0_d  = req_rd_is_x0;
          rv_d    = '0;
          ill_d   = 1'b0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        csr_rd_en = do_read && !illegal && !flush;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (illegal) begin
          ill_d   = 1'b1;
          rv_d    = '0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // flush no longer matters: the commit is architectural
        old_val = do_read ? csr_rd_data : '0;
        unique case (f3_op(f3_q))
          OP_RS:   new_val = old_val | src_q;
          OP_RC:   new_val = old_val & ~src_q;
          default: new_val = src_q;
        endcase
        csr_wr_en   = do_write;
        csr_wr_data = new_val;
        rv_d        = old_val;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign csr_addr      = addr_q;
  assign resp_rd_value = rv_q;
  assign resp_illegal  = ill_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Randomized bench for csr_access_ctrl with a behavioural CSR
// storage and a transaction-level reference model.
module tb_csr_access_ctrl;
  import csr_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [4:0]  req_rs1_field;
  logic [31:0] req_rs1_val;
  logic        req_rd_is_x0;
  logic [1:0]  priv_mode;
  logic        flush;
  logic [11:0] csr_addr;
  logic        csr_exists;
  logic        csr_rd_en;
  logic [31:0] csr_rd_data;
  logic        csr_wr_en;
  logic [31:0] csr_wr_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rd_value;
  logic        resp_illegal;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  bit          ex      [0:4095];
  logic [11:0] alist   [0:8];

  csr_access_ctrl #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_rs1_field(req_rs1_field), .req_rs1_val(req_rs1_val),
    .req_rd_is_x0(req_rd_is_x0), .priv_mode(priv_mode),
    .flush(flush), .csr_addr(csr_addr),
    .csr_exists(csr_exists), .csr_rd_en(csr_rd_en),
    .csr_rd_data(csr_rd_data), .csr_wr_en(csr_wr_en),
    .csr_wr_data(csr_wr_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rd_value(resp_rd_value),
    .resp_illegal(resp_illegal), .busy(busy)
  );

  always #5 clock = ~clock;

  // storage: read data one cycle after strobe, write on strobe
  assign csr_exists = ex[csr_addr];
  always @(posedge clock) begin
    if (csr_rd_en) csr_rd_data <= mem[csr_addr];
    if (csr_wr_en) mem[csr_addr] <= csr_wr_data;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic setmem(input logic [11:0] a,
                        input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // reference: the architectural effect of one CSR instruction
  task automatic model(input logic [2:0] f3,
                       input logic [11:0] a,
                       input logic [4:0] rs1f,
                       input logic [31:0] rs1v,
                       input logic rdx0,
                       input logic [1:0] pv,
                       output bit ill, output bit rd,
                       output bit wr, output logic [31:0] wd,
                       output logic [31:0] rv);
    logic [31:0] src, old;
    int op;
    op  = int'(f3[1:0]);
    src = f3[2] ? {27'd0, rs1f} : rs1v;
    wr  = (op == 1) || (rs1f != 0);
    rd  = (op != 1) || !rdx0;
    ill = (op == 0) || !ex[a] || (int'(pv) < int'(a[9:8]))
       || (wr && a[11:10] == 2'b11);
    old = rd ? ref_mem[a] : 32'd0;
    if (op == 1)      wd = src;
    else if (op == 2) wd = old | src;
    else              wd = old & ~src;
    rv = ill ? 32'd0 : old;
    if (ill) begin
      rd = 0;
      wr = 0;
    end
  endtask

  task automatic run_req(input logic [2:0] f3,
                         input logic [11:0] a,
                         input logic [4:0] rs1f,
                         input logic [31:0] rs1v,
                         input logic rdx0,
                         input logic [1:0] pv,
                         input int fl_at,
                         input int hold);
    bit e_ill, e_rd, e_wr, fl, done;
    logic [31:0] e_wd, e_rv, g_wd, g_rv;
    logic g_il;
    int n_rd, n_wr, c_rd, c_wr, c_resp;
    model(f3, a, rs1f, rs1v, rdx0, pv, e_ill, e_rd, e_wr, e_wd, e_rv);
    fl = (fl_at == 1);
    if (fl) begin
      e_rd = 0;
      e_wr = 0;
    end
    n_rd = 0; n_wr = 0; c_rd = -1; c_wr = -1; c_resp = -1;
    g_wd = 0; g_rv = 0; g_il = 0; done = 0;
    @(negedge clock);
    check("idle_rdy", {31'd0, req_ready}, 32'd1);
    priv_mode     = pv;
    req_funct3    = f3;
    req_addr      = a;
    req_rs1_field = rs1f;
    req_rs1_val   = rs1v;
    req_rd_is_x0  = rdx0;
    req_valid     = 1;
    @(negedge clock);
    req_valid     = 0;
    req_funct3    = 3'($urandom);
    req_addr      = 12'($urandom);
    req_rs1_field = 5'($urandom);
    req_rs1_val   = $urandom;
    req_rd_is_x0  = 1'($urandom);
    for (int c = 1; c <= hold + 8; c++) begin
      flush = (c == fl_at);
      #1;
      if (csr_rd_en) begin n_rd++; c_rd = c; end
      if (csr_wr_en) begin
        n_wr++; c_wr = c; g_wd = csr_wr_data;
      end
      if (resp_valid) begin
        if (c_resp < 0) begin
          c_resp = c; g_rv = resp_rd_value; g_il = resp_illegal;
        end else begin
          check("hold_rv", resp_rd_value, g_rv);
          check("hold_il", {31'd0, resp_illegal}, {31'd0, g_il});
        end
        check("resp_nordy", {31'd0, req_ready}, 32'd0);
        resp_ready = (c >= c_resp + hold);
      end else begin
        resp_ready = 0;
      end
      @(negedge clock);
      if (resp_ready) begin
        resp_ready = 0;
        flush = 0;
        check("post_valid", {31'd0, resp_valid}, 32'd0);
        check("post_rdy", {31'd0, req_ready}, 32'd1);
        done = 1;
        break;
      end
    end
    flush = 0;
    resp_ready = 0;
    check("n_rd", n_rd, e_rd ? 1 : 0);
    if (e_rd) check("c_rd", c_rd, 1);
    check("n_wr", n_wr, e_wr ? 1 : 0);
    if (e_wr) begin
      check("c_wr", c_wr, 2);
      check("wr_data", g_wd, e_wd);
      ref_mem[a] = e_wd;
    end
    check("c_resp", c_resp, fl ? -1 : (e_ill ? 2 : 3));
    if (!fl) begin
      check("rd_value", g_rv, e_rv);
      check("illegal", {31'd0, g_il}, {31'd0, e_ill});
      check("hshake", {31'd0, done}, 32'd1);
    end
    check("end_busy", {31'd0, busy}, 32'd0);
    check("store", mem[a], ref_mem[a]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rden"}, {31'd0, csr_rd_en}, 32'd0);
    check({tag, "_wren"}, {31'd0, csr_wr_en}, 32'd0);
    check({tag, "_rv"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ill"}, {31'd0, resp_illegal}, 32'd0);
    check({tag, "_rdval"}, resp_rd_value, 32'd0);
    check({tag, "_addr"}, {20'd0, csr_addr}, 32'd0);
    check({tag, "_wdata"}, csr_wr_data, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_in_write(input logic [11:0] a);
    @(negedge clock);
    priv_mode = 2'd3; req_funct3 = F3_CSRRW; req_addr = a;
    req_rs1_field = 5'd7; req_rs1_val = 32'hA5A5_5A5A;
    req_rd_is_x0 = 0; req_valid = 1;
    @(negedge clock);
    req_valid = 0;
    @(negedge clock);
    #1;
    check("rst_pre_wr", {31'd0, csr_wr_en}, 32'd1);
    reset = 1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    check("rst_nowr", mem[a], ref_mem[a]);
    check_reset_vals("rst_after");
  endtask

  initial begin
    bit ill, rd, wr;
    logic [31:0] wd, rv;
    alist[0] = 12'h340; alist[1] = 12'h300; alist[2] = 12'hC00;
    alist[3] = 12'h305; alist[4] = 12'h141; alist[5] = 12'h001;
    alist[6] = 12'hF11; alist[7] = 12'h7C0; alist[8] = 12'h100;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 0; ref_mem[i] = 0; ex[i] = 0;
    end
    for (int i = 0; i < 9; i++) begin
      setmem(alist[i], $urandom);
      ex[alist[i]] = (alist[i] != 12'h7C0);
    end
    reset = 1; req_valid = 0; req_funct3 = 0; req_addr = 0;
    req_rs1_field = 0; req_rs1_val = 0; req_rd_is_x0 = 0;
    priv_mode = 2'd3; flush = 0; resp_ready = 0;
    csr_rd_data = 0;
    #1;
    check_reset_vals("por");
    @(negedge clock);
    @(negedge clock);
    reset = 0;

    setmem(12'h340, 32'h1234_5678);
    run_req(F3_CSRRW, 12'h340, 5'd9, 32'hDEAD_BEEF, 0, 2'd3, 0, 0);
    setmem(12'h340, 32'h0000_000A);
    run_req(F3_CSRRSI, 12'h340, 5'd5, 32'hFFFF_0000, 0, 2'd3, 0, 0);
    run_req(F3_CSRRC, 12'h340, 5'd2, 32'h0000_0003, 0, 2'd3, 0, 0);
    check("rc_val", mem[12'h340], 32'h0000_000C);
    run_req(F3_CSRRS, 12'hC00, 5'd0, 32'hFFFF_FFFF, 0, 2'd3, 0, 0);
    run_req(F3_CSRRS, 12'hC00, 5'd1, 32'hFFFF_FFFF, 0, 2'd3, 0, 0);
    run_req(F3_CSRRW, 12'h300, 5'd1, 32'h1, 0, 2'd0, 0, 0);
    run_req(F3_CSRRW, 12'h7C0, 5'd1, 32'h1, 0, 2'd3, 0, 0);
    run_req(F3_CSRRW, 12'h305, 5'd1, 32'h55, 1, 2'd3, 0, 0);
    run_req(3'b100, 12'h340, 5'd1, 32'h1, 0, 2'd3, 0, 0);
    run_req(F3_CSRRW, 12'h340, 5'd3, 32'h7777, 0, 2'd3, 1, 0);
    run_req(F3_CSRRW, 12'h340, 5'd3, 32'h8888, 0, 2'd3, 2, 0);
    run_req(F3_CSRRCI, 12'h141, 5'd31, 32'h0, 0, 2'd1, 0, 5);
    model(F3_CSRRW, 12'h340, 5'd7, 32'hA5A5_5A5A, 0, 2'd3,
          ill, rd, wr, wd, rv);
    check("rst_legal", {31'd0, ill}, 32'd0);
    reset_in_write(12'h340);

    for (int i = 0; i < 150; i++) begin
      logic [4:0] rf;
      logic [1:0] pv;
      int fa, sel;
      rf  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      sel = $urandom_range(0, 2);
      pv  = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd1 : 2'd3;
      sel = $urandom_range(0, 9);
      fa  = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
      run_req(3'($urandom), alist[$urandom_range(0, 8)], rf,
              $urandom, 1'($urandom), pv, fa,
              $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
